// File: rtl/fdt_search.sv
// rtl/fdt_search.sv - free-line search over per-size full vectors with one-outstanding alloc tracking
module fdt_search #(
  parameter int TIMEOUT_CYCLES      = 255,
  parameter int REQ_ID_WIDTH        = 8,
  parameter int REQ_SIZE_TYPE_WIDTH = 2,
  parameter int AT_TREE_INDEX_WIDTH = 6,
  parameter int FDT_INDEX_WIDTH     = 6,
  parameter int FDT_BIT_WIDTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [REQ_ID_WIDTH-1:0]        req_id,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_size,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_origin_size,
  output logic                           alloc_valid_fdt_out,
  output logic [REQ_ID_WIDTH-1:0]        alloc_id_fdt_out,
  output logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_fdt_out,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_fdt_out,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_origin_size_fdt_out,
  output logic                           alloc_fail_valid,
  output logic [REQ_ID_WIDTH-1:0]        alloc_fail_id,
  input  logic                           fdt_update_valid,
  input  logic [FDT_INDEX_WIDTH-1:0]     fdt_update_idx,
  input  logic [FDT_BIT_WIDTH-1:0]       fdt_update_bit_sequence,
  input  logic                           ort_alloc_done,
  output logic                           timeout_err
);

  // Size class codes (512B, 1K, 2K, 4K) index the full vectors directly.
  localparam int ROWS  = 1 << FDT_INDEX_WIDTH;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [ROWS-1:0]                full_q [FDT_BIT_WIDTH];
  logic [ROWS-1:0]                full_d [FDT_BIT_WIDTH];
  logic [CNT_W-1:0]               wait_cnt_q, wait_cnt_d;
  logic [REQ_ID_WIDTH-1:0]        req_id_q, req_id_d;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_size_q, req_size_d;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_origin_q, req_origin_d;

  logic                           req_ready_q, req_ready_d;
  logic                           alloc_valid_q, alloc_valid_d;
  logic [REQ_ID_WIDTH-1:0]        alloc_id_q, alloc_id_d;
  logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_q, alloc_pos_d;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_q, alloc_size_d;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_origin_q, alloc_origin_d;
  logic                           fail_valid_q, fail_valid_d;
  logic [REQ_ID_WIDTH-1:0]        fail_id_q, fail_id_d;
  logic                           timeout_q, timeout_d;

  logic                           free_found;
  logic [AT_TREE_INDEX_WIDTH-1:0] free_pos;

  // Row-full updates from and_tree apply in every state and only touch one row.
  always_comb begin
    for (int k = 0; k < FDT_BIT_WIDTH; k++) begin
      full_d[k] = full_q[k];
      if (fdt_update_valid) begin
        full_d[k][fdt_update_idx] = fdt_update_bit_sequence[k];
      end
    end
  end

  // Lowest-index free line of the captured size class, from the registered vector only.
  always_comb begin
    free_found = 1'b0;
    free_pos   = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!full_q[req_size_q][r]) begin
        free_found = 1'b1;
        free_pos   = AT_TREE_INDEX_WIDTH'(r);
      end
    end
  end

  // Control FSM: capture in IDLE, single-cycle SEARCH, WAIT for or_tree completion or timeout.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    req_id_d       = req_id_q;
    req_size_d     = req_size_q;
    req_origin_d   = req_origin_q;
    alloc_valid_d  = 1'b0;
    alloc_id_d     = alloc_id_q;
    alloc_pos_d    = alloc_pos_q;
    alloc_size_d   = alloc_size_q;
    alloc_origin_d = alloc_origin_q;
    fail_valid_d   = 1'b0;
    fail_id_d      = fail_id_q;
    timeout_d      = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_id_d     = req_id;
          req_size_d   = req_size;
          req_origin_d = req_origin_size;
          state_d      = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (free_found) begin
          alloc_valid_d  = 1'b1;
          alloc_id_d     = req_id_q;
          alloc_pos_d    = free_pos;
          alloc_size_d   = req_size_q;
          alloc_origin_d = req_origin_q;
          wait_cnt_d     = '0;
          state_d        = ST_WAIT;
        end else begin
          fail_valid_d = 1'b1;
          fail_id_d    = req_id_q;
          state_d      = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Completion wins over a coinciding expiry and leaves the error flag alone.
        if (ort_alloc_done) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State, vectors and registered outputs; reset drops any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      full_q         <= '{default: '0};
      wait_cnt_q     <= '0;
      req_id_q       <= '0;
      req_size_q     <= '0;
      req_origin_q   <= '0;
      req_ready_q    <= 1'b0;
      alloc_valid_q  <= 1'b0;
      alloc_id_q     <= '0;
      alloc_pos_q    <= '0;
      alloc_size_q   <= '0;
      alloc_origin_q <= '0;
      fail_valid_q   <= 1'b0;
      fail_id_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      wait_cnt_q     <= wait_cnt_d;
      req_id_q       <= req_id_d;
      req_size_q     <= req_size_d;
      req_origin_q   <= req_origin_d;
      req_ready_q    <= req_ready_d;
      alloc_valid_q  <= alloc_valid_d;
      alloc_id_q     <= alloc_id_d;
      alloc_pos_q    <= alloc_pos_d;
      alloc_size_q   <= alloc_size_d;
      alloc_origin_q <= alloc_origin_d;
      fail_valid_q   <= fail_valid_d;
      fail_id_q      <= fail_id_d;
      timeout_q      <= timeout_d;
    end
  end

  assign req_ready                 = req_ready_q;
  assign alloc_valid_fdt_out       = alloc_valid_q;
  assign alloc_id_fdt_out          = alloc_id_q;
  assign alloc_pos_fdt_out         = alloc_pos_q;
  assign alloc_size_fdt_out        = alloc_size_q;
  assign alloc_origin_size_fdt_out = alloc_origin_q;
  assign alloc_fail_valid          = fail_valid_q;
  assign alloc_fail_id             = fail_id_q;
  assign timeout_err               = timeout_q;

endmodule
